mem_port_arbiter: RTL and testbench

Arbiter sharing the core's single memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (loads/stores). It sits between the pipeline's fetch/data request ports and the external bus. It allows one outstanding transaction and routes each response back to its owner. It drops stale fetch responses after a PC redirect, and bounds data-side priority so fetch cannot starve.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared core definitions for the memory port arbiter: transaction owner
// encoding and small data-path helpers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'b00,
    OWNER_INSTR = 2'b01,
    OWNER_DATA  = 2'b10
  } owner_e;

  // Forces a data word to zero unless its qualifier is set.
  function automatic logic [31:0] gate_word(input logic en, input logic [31:0] val);
    logic [31:0] res;
    if (en) begin
      res = val;
    end else begin
      res = 32'h0000_0000;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single memory bus between instruction fetch and the data stage:
// one outstanding transaction, response routing, flush discard, bounded data priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        flush_i,
  input  logic        ireq_i,
  input  logic [31:0] iaddr_i,
  output logic        igrant_o,
  output logic        irvalid_o,
  output logic [31:0] irdata_o,
  input  logic        dreq_i,
  input  logic        dwe_i,
  input  logic [3:0]  dbe_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  output logic        dgrant_o,
  output logic        drvalid_o,
  output logic [31:0] drdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int              SW         = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [SW-1:0]   STREAK_ONE = SW'(1);
  localparam logic [SW-1:0]   STREAK_ZERO = SW'(0);

  owner_e        owner_r;
  logic          discard_r;
  logic [SW-1:0] streak_r;

  logic can_issue_s;
  logic sel_data_s;
  logic sel_instr_s;
  logic ivalid_s;
  logic dvalid_s;

  // Request selection; nothing is offered while reset is held so outputs stay low.
  always_comb begin
    can_issue_s = rstn_i && ((owner_r == OWNER_NONE) || bus_rvalid_i);
    sel_data_s  = can_issue_s && dreq_i && !(ireq_i && (streak_r == STREAK_MAX));
    sel_instr_s = can_issue_s && !sel_data_s && ireq_i && !flush_i;
  end

  // Drive the bus from the selected requester; idle fields are zeroed.
  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_be_o    = 4'b0000;
    bus_addr_o  = 32'h0000_0000;
    bus_wdata_o = 32'h0000_0000;
    if (sel_data_s) begin
      bus_req_o   = 1'b1;
      bus_we_o    = dwe_i;
      bus_be_o    = dbe_i;
      bus_addr_o  = daddr_i;
      bus_wdata_o = dwdata_i;
    end else if (sel_instr_s) begin
      bus_req_o   = 1'b1;
      bus_be_o    = 4'b1111;
      bus_addr_o  = iaddr_i;
    end else begin
      bus_req_o   = 1'b0;
    end
  end

  // Grants and response routing back to the owner of the outstanding transaction.
  always_comb begin
    igrant_o  = bus_gnt_i && bus_req_o && sel_instr_s;
    dgrant_o  = bus_gnt_i && bus_req_o && sel_data_s;
    ivalid_s  = bus_rvalid_i && (owner_r == OWNER_INSTR) && !discard_r && !flush_i;
    dvalid_s  = bus_rvalid_i && (owner_r == OWNER_DATA);
    irvalid_o = ivalid_s;
    drvalid_o = dvalid_s;
    irdata_o  = gate_word(ivalid_s, bus_rdata_i);
    drdata_o  = gate_word(dvalid_s, bus_rdata_i);
  end

  // Owner of the outstanding transaction; a new grant takes precedence over completion.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_r <= OWNER_NONE;
    end else if (dgrant_o) begin
      owner_r <= OWNER_DATA;
    end else if (igrant_o) begin
      owner_r <= OWNER_INSTR;
    end else if (bus_rvalid_i) begin
      owner_r <= OWNER_NONE;
    end else begin
      owner_r <= owner_r;
    end
  end

  // Marks an in-flight fetch as stale after a redirect until its response drains.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      discard_r <= 1'b0;
    end else if (bus_rvalid_i && (owner_r == OWNER_INSTR)) begin
      discard_r <= 1'b0;
    end else if (flush_i && (owner_r == OWNER_INSTR)) begin
      discard_r <= 1'b1;
    end else begin
      discard_r <= discard_r;
    end
  end

  // Counts back-to-back data grants that bypassed a waiting fetch.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      streak_r <= STREAK_ZERO;
    end else if (igrant_o || !ireq_i) begin
      streak_r <= STREAK_ZERO;
    end else if (dgrant_o && (streak_r != STREAK_MAX)) begin
      streak_r <= streak_r + STREAK_ONE;
    end else begin
      streak_r <= streak_r;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected grant/response
// events into a queue, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  localparam int K_DR = 0;
  localparam int K_IR = 1;
  localparam int K_DG = 2;
  localparam int K_IG = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } evt_t;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        flush_i;
  logic        ireq_i;
  logic [31:0] iaddr_i;
  logic        igrant_o;
  logic        irvalid_o;
  logic [31:0] irdata_o;
  logic        dreq_i;
  logic        dwe_i;
  logic [3:0]  dbe_i;
  logic [31:0] daddr_i;
  logic [31:0] dwdata_i;
  logic        dgrant_o;
  logic        drvalid_o;
  logic [31:0] drdata_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  evt_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  mem_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .ireq_i(ireq_i), .iaddr_i(iaddr_i), .igrant_o(igrant_o),
    .irvalid_o(irvalid_o), .irdata_o(irdata_o),
    .dreq_i(dreq_i), .dwe_i(dwe_i), .dbe_i(dbe_i), .daddr_i(daddr_i),
    .dwdata_i(dwdata_i), .dgrant_o(dgrant_o), .drvalid_o(drvalid_o),
    .drdata_o(drdata_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic string kname(input int k);
    case (k)
      K_DR:    return "drvalid";
      K_IR:    return "irvalid";
      K_DG:    return "dgrant";
      K_IG:    return "igrant";
      default: return "none";
    endcase
  endfunction

  task automatic push(input int k, input logic [31:0] a, input logic w,
                      input logic [3:0] b, input logic [31:0] wd, input logic [31:0] rd);
    evt_t e;
    e.kind = k; e.addr = a; e.we = w; e.be = b; e.wdata = wd; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic push_ig(input logic [31:0] a);
    push(K_IG, a, 1'b0, 4'b0000, 32'h0, 32'h0);
  endtask
  task automatic push_dg(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] wd);
    push(K_DG, a, w, b, wd, 32'h0);
  endtask
  task automatic push_ir(input logic [31:0] rd);
    push(K_IR, 32'h0, 1'b0, 4'b0000, 32'h0, rd);
  endtask
  task automatic push_dr(input logic [31:0] rd);
    push(K_DR, 32'h0, 1'b0, 4'b0000, 32'h0, rd);
  endtask

  // Compare one observed output event against the head of the expectation queue.
  task automatic check_evt(input int k);
    evt_t e;
    logic ok;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_%s: event seen at %0t, expected no event", kname(k), $time);
    end else begin
      e  = exp_q.pop_front();
      ok = (e.kind == k);
      if (ok && (k == K_IG)) ok = (bus_addr_o == e.addr) && (bus_we_o == 1'b0);
      if (ok && (k == K_DG)) ok = (bus_addr_o == e.addr) && (bus_we_o == e.we) &&
                                  (bus_be_o == e.be) && (bus_wdata_o == e.wdata);
      if (ok && (k == K_IR)) ok = (irdata_o == e.rdata);
      if (ok && (k == K_DR)) ok = (drdata_o == e.rdata);
      if (ok) begin
        passed++;
      end else begin
        $display("FAIL %s at %0t: got kind=%s addr=%h we=%b be=%h wdata=%h irdata=%h drdata=%h, expected kind=%s addr=%h we=%b be=%h wdata=%h rdata=%h",
                 kname(k), $time, kname(k), bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
                 irdata_o, drdata_o, kname(e.kind), e.addr, e.we, e.be, e.wdata, e.rdata);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Monitor: responses are checked before grants within a cycle.
  always @(negedge clk_i) begin
    if (drvalid_o === 1'b1) check_evt(K_DR);
    if (irvalid_o === 1'b1) check_evt(K_IR);
    if (dgrant_o === 1'b1)  check_evt(K_DG);
    if (igrant_o === 1'b1)  check_evt(K_IG);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ireq_i = 1'b0; dreq_i = 1'b0; flush_i = 1'b0; dwe_i = 1'b0;
    dbe_i = 4'b0000; daddr_i = 32'h0; dwdata_i = 32'h0; iaddr_i = 32'h0;
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0; bus_gnt_i = 1'b1;
  endtask

  task automatic resp(input logic [31:0] rd);
    bus_rvalid_i = 1'b1; bus_rdata_i = rd;
  endtask

  initial begin
    idle();
    rstn_i = 1'b0;
    ireq_i = 1'b1; iaddr_i = 32'h0000_0100;

    // Reset state with a fetch already waiting
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_val("reset_bus_req", {31'h0, bus_req_o}, 32'h0);
    check_val("reset_igrant", {31'h0, igrant_o}, 32'h0);
    check_val("reset_bus_addr", bus_addr_o, 32'h0);
    check_val("reset_irvalid", {31'h0, irvalid_o}, 32'h0);
    tick();
    rstn_i = 1'b1;
    push_ig(32'h0000_0100);
    tick();
    ireq_i = 1'b0; resp(32'h0000_0013); push_ir(32'h0000_0013);
    tick();
    idle();
    tick();

    // Simultaneous requests: data first, fetch granted alongside the data response
    ireq_i = 1'b1; iaddr_i = 32'h0000_0104;
    dreq_i = 1'b1; daddr_i = 32'h0000_2000; dbe_i = 4'b1111;
    push_dg(32'h0000_2000, 1'b0, 4'b1111, 32'h0);
    tick();
    dreq_i = 1'b0; resp(32'hAAAA_5555);
    push_dr(32'hAAAA_5555); push_ig(32'h0000_0104);
    tick();
    ireq_i = 1'b0; resp(32'h0000_0011); push_ir(32'h0000_0011);
    tick();
    idle();
    tick();

    // Data streak bound: four data grants, one fetch, then data resumes
    ireq_i = 1'b1; iaddr_i = 32'h0000_0200;
    dreq_i = 1'b1; daddr_i = 32'h0000_2100; dbe_i = 4'b1111;
    push_dg(32'h0000_2100, 1'b0, 4'b1111, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      resp(32'h0000_1000 + i);
      push_dr(32'h0000_1000 + i); push_dg(32'h0000_2100, 1'b0, 4'b1111, 32'h0);
      tick();
    end
    resp(32'h0000_1003); push_dr(32'h0000_1003); push_ig(32'h0000_0200);
    tick();
    resp(32'h2001_0000); push_ir(32'h2001_0000); push_dg(32'h0000_2100, 1'b0, 4'b1111, 32'h0);
    tick();
    resp(32'h0000_1004); push_dr(32'h0000_1004); push_dg(32'h0000_2100, 1'b0, 4'b1111, 32'h0);
    tick();
    dreq_i = 1'b0; resp(32'h0000_1005); push_dr(32'h0000_1005); push_ig(32'h0000_0200);
    tick();
    ireq_i = 1'b0; resp(32'h0000_0200); push_ir(32'h0000_0200);
    tick();
    idle();
    tick();

    // Flush while a fetch is outstanding: stale response dropped, new fetch proceeds
    ireq_i = 1'b1; iaddr_i = 32'h0000_0300; push_ig(32'h0000_0300);
    tick();
    ireq_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    ireq_i = 1'b1; iaddr_i = 32'h0000_0400; resp(32'h0000_0BAD);
    push_ig(32'h0000_0400);
    tick();
    ireq_i = 1'b0; resp(32'h0000_600D); push_ir(32'h0000_600D);
    tick();
    idle();
    tick();

    // Flush coinciding with the fetch response: drop it, suppress issue, no discard
    ireq_i = 1'b1; iaddr_i = 32'h0000_0500; push_ig(32'h0000_0500);
    tick();
    iaddr_i = 32'h0000_0504; flush_i = 1'b1; resp(32'h0000_0077);
    tick();
    flush_i = 1'b0; bus_rvalid_i = 1'b0; push_ig(32'h0000_0504);
    tick();
    ireq_i = 1'b0; resp(32'h0000_0088); push_ir(32'h0000_0088);
    tick();
    idle();
    tick();

    // Store with partial byte enables
    dreq_i = 1'b1; dwe_i = 1'b1; dbe_i = 4'b0011; daddr_i = 32'h0000_3000; dwdata_i = 32'hDEAD_BEEF;
    push_dg(32'h0000_3000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    tick();
    idle(); resp(32'h1234_5678); push_dr(32'h1234_5678);
    tick();
    idle();

    // Bus not granting: request stays presented and is not latched
    dreq_i = 1'b1; daddr_i = 32'h0000_2400; dbe_i = 4'b1111; bus_gnt_i = 1'b0;
    @(negedge clk_i);
    check_val("nognt_bus_req", {31'h0, bus_req_o}, 32'h1);
    check_val("nognt_bus_addr", bus_addr_o, 32'h0000_2400);
    tick();
    bus_gnt_i = 1'b1; push_dg(32'h0000_2400, 1'b0, 4'b1111, 32'h0);
    tick();
    dreq_i = 1'b0; resp(32'h0000_0055); push_dr(32'h0000_0055);
    tick();
    idle();
    @(negedge clk_i);
    check_val("idle_bus_req", {31'h0, bus_req_o}, 32'h0);
    check_val("idle_bus_addr", bus_addr_o, 32'h0);
    tick();

    // Reset mid data transaction, then a stray response must vanish
    dreq_i = 1'b1; daddr_i = 32'h0000_2200; dbe_i = 4'b1111;
    push_dg(32'h0000_2200, 1'b0, 4'b1111, 32'h0);
    tick();
    idle(); rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    tick();
    resp(32'h0000_FFFF);
    @(negedge clk_i);
    check_val("stray_drvalid", {31'h0, drvalid_o}, 32'h0);
    check_val("stray_irvalid", {31'h0, irvalid_o}, 32'h0);
    tick();
    idle();
    dreq_i = 1'b1; daddr_i = 32'h0000_2204; dbe_i = 4'b1111;
    push_dg(32'h0000_2204, 1'b0, 4'b1111, 32'h0);
    tick();
    idle(); resp(32'h0000_0066); push_dr(32'h0000_0066);
    tick();
    idle();
    repeat (2) tick();

    check_val("pending_expectations", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
